// File: rtl/jtag_scan_master_pkg.sv
`default_nettype none
// ============================================================================
// jtag_scan_pkg : command codes, FSM states and TMS walk patterns
// Revision: 1.0
// ============================================================================
package jtag_scan_pkg;

    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_IR    = 2'd1;
    localparam logic [1:0] CMD_DR    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST_SEQ = 3'd1,
        ST_SEL     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_EXIT    = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    // Bit 0 is the TMS value of the first TCK cycle; *_LAST is the final step index.
    localparam logic [3:0] TMS_PRE_IR          = 4'b0011;
    localparam logic [1:0] TMS_PRE_IR_LAST     = 2'd3;
    localparam logic [3:0] TMS_PRE_DR          = 4'b0001;
    localparam logic [1:0] TMS_PRE_DR_LAST     = 2'd2;
    localparam logic [3:0] TMS_POST_EARLY      = 4'b0001;
    localparam logic [1:0] TMS_POST_EARLY_LAST = 2'd1;
    localparam logic [3:0] TMS_POST_PAUSE      = 4'b0110;
    localparam logic [1:0] TMS_POST_PAUSE_LAST = 2'd3;

    function automatic logic tms_bit(input logic [3:0] pat, input logic [1:0] idx);
        return pat[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_scan_master_if.sv
`default_nettype none
// ============================================================================
// jtag_scan_master_if : command / response handshake bundle
// Revision: 1.0
// ============================================================================
interface jtag_scan_master_if #(
    parameter int MAX_DR_BITS = 64,
    parameter int NB_W        = $clog2(MAX_DR_BITS + 1)
);
    import jtag_scan_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_type;
    logic [NB_W-1:0]        cmd_nbits;
    logic [MAX_DR_BITS-1:0] cmd_tdi;
    logic                   cmd_pause;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [MAX_DR_BITS-1:0] rsp_tdo;

    modport master (
        output cmd_valid, cmd_type, cmd_nbits, cmd_tdi, cmd_pause, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tdo
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_nbits, cmd_tdi, cmd_pause, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tdo
    );

endinterface
`default_nettype wire

// File: rtl/jtag_scan_master_tck_gen.sv
`default_nettype none
// ============================================================================
// jtag_tck_gen : TCK divider with single-clk rise/fall strobes
// Revision: 1.0
// ============================================================================
module jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int              CNT_W    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tck_q, tck_d;
    logic             w_term;

    // Strobes mark the clk edge on which tck_q toggles.
    assign w_term = en_i && (cnt_q == CNT_LAST);
    assign rise_o = w_term && !tck_q;
    assign fall_o = w_term && tck_q;
    assign tck_o  = tck_q;

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!en_i) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (w_term) begin
            cnt_d = '0;
            tck_d = !tck_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_scan_master.sv
`default_nettype none
// ============================================================================
// jtag_scan_master : turns RESET / IR / DR commands into TCK/TMS/TDI walks
// Revision: 1.0
// ============================================================================
module jtag_scan_master
    import jtag_scan_pkg::*;
#(
    parameter int IR_LENGTH        = 4,
    parameter int MAX_DR_BITS      = 64,
    parameter int TCK_DIV          = 2,
    parameter int RESET_TMS_CYCLES = 5
) (
    input  logic                clk,
    input  logic                rst,
    jtag_scan_master_if.slave   bus,
    output logic                tck_o,
    output logic                tms_o,
    output logic                tdi_o,
    input  logic                tdo_i,
    output logic                busy_o,
    output logic                tap_synced_o
);
    localparam int NB_W   = $clog2(MAX_DR_BITS + 1);
    localparam int BIT_W  = $clog2(MAX_DR_BITS);
    localparam int STEP_W = ($clog2(RESET_TMS_CYCLES + 1) > 2) ? $clog2(RESET_TMS_CYCLES + 1) : 2;

    localparam logic [NB_W-1:0]   NB_MAX   = NB_W'(MAX_DR_BITS);
    localparam logic [BIT_W-1:0]  DR_LAST  = BIT_W'(MAX_DR_BITS - 1);
    localparam logic [BIT_W-1:0]  IR_LAST  = BIT_W'(IR_LENGTH - 1);
    localparam logic [STEP_W-1:0] RST_LAST = STEP_W'(RESET_TMS_CYCLES);

    state_t                 state_q, state_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [BIT_W-1:0]       last_q, last_d;
    logic                   is_reset_q, is_reset_d;
    logic                   is_ir_q, is_ir_d;
    logic                   pause_q, pause_d;
    logic [MAX_DR_BITS-1:0] tdi_vec_q, tdi_vec_d;
    logic [MAX_DR_BITS-1:0] tdo_vec_q, tdo_vec_d;
    logic                   tms_q, tms_d;
    logic                   tdi_q, tdi_d;
    logic                   synced_q, synced_d;

    logic                   w_busy, w_rise, w_fall;
    logic                   w_cmd_ir, w_cmd_reset;
    logic [BIT_W-1:0]       w_dr_last;
    logic [STEP_W-1:0]      w_step_nxt;
    logic [BIT_W-1:0]       w_bit_nxt;
    logic [3:0]             w_pre, w_post;
    logic [1:0]             w_pre_last, w_post_last;

    assign w_busy = (state_q == ST_RST_SEQ) || (state_q == ST_SEL) ||
                    (state_q == ST_SHIFT)   || (state_q == ST_EXIT);

    jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk    (clk),
        .rst    (rst),
        .en_i   (w_busy),
        .tck_o  (tck_o),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    assign w_cmd_ir    = (bus.cmd_type == CMD_IR);
    assign w_cmd_reset = !((bus.cmd_type == CMD_IR) || (bus.cmd_type == CMD_DR));
    assign w_step_nxt  = step_q + 1'b1;
    assign w_bit_nxt   = bit_q + 1'b1;
    assign w_pre       = is_ir_q ? TMS_PRE_IR      : TMS_PRE_DR;
    assign w_pre_last  = is_ir_q ? TMS_PRE_IR_LAST : TMS_PRE_DR_LAST;
    assign w_post      = pause_q ? TMS_POST_PAUSE      : TMS_POST_EARLY;
    assign w_post_last = pause_q ? TMS_POST_PAUSE_LAST : TMS_POST_EARLY_LAST;

    // A zero length still shifts one bit; oversize lengths saturate.
    always_comb begin
        if (bus.cmd_nbits == '0)
            w_dr_last = '0;
        else if (bus.cmd_nbits > NB_MAX)
            w_dr_last = DR_LAST;
        else
            w_dr_last = BIT_W'(bus.cmd_nbits - 1'b1);
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        bit_d      = bit_q;
        last_d     = last_q;
        is_reset_d = is_reset_q;
        is_ir_d    = is_ir_q;
        pause_d    = pause_q;
        tdi_vec_d  = tdi_vec_q;
        tdo_vec_d  = tdo_vec_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        synced_d   = synced_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    is_reset_d = w_cmd_reset;
                    is_ir_d    = w_cmd_ir;
                    pause_d    = bus.cmd_pause && (bus.cmd_type == CMD_DR);
                    tdi_vec_d  = bus.cmd_tdi;
                    tdo_vec_d  = '0;
                    last_d     = w_cmd_ir ? IR_LAST : w_dr_last;
                    step_d     = '0;
                    bit_d      = '0;
                    tdi_d      = 1'b0;
                    if (!w_cmd_reset && synced_q) begin
                        state_d = ST_SEL;
                        tms_d   = tms_bit(w_cmd_ir ? TMS_PRE_IR : TMS_PRE_DR, 2'd0);
                    end else begin
                        state_d = ST_RST_SEQ;
                        tms_d   = 1'b1;
                    end
                end
            end
            ST_RST_SEQ: begin
                if (w_fall) begin
                    step_d = w_step_nxt;
                    tms_d  = (w_step_nxt < RST_LAST);
                    if (step_q == RST_LAST) begin
                        synced_d = 1'b1;
                        step_d   = '0;
                        if (is_reset_q) begin
                            state_d = ST_RESP;
                            tms_d   = 1'b0;
                        end else begin
                            state_d = ST_SEL;
                            tms_d   = tms_bit(w_pre, 2'd0);
                        end
                    end
                end
            end
            ST_SEL: begin
                if (w_fall) begin
                    if (step_q == STEP_W'(w_pre_last)) begin
                        state_d = ST_SHIFT;
                        bit_d   = '0;
                        tms_d   = (last_q == '0);
                        tdi_d   = tdi_vec_q[0];
                    end else begin
                        step_d = w_step_nxt;
                        tms_d  = tms_bit(w_pre, w_step_nxt[1:0]);
                    end
                end
            end
            ST_SHIFT: begin
                if (w_rise)
                    tdo_vec_d[bit_q] = tdo_i;
                if (w_fall) begin
                    if (bit_q == last_q) begin
                        state_d = ST_EXIT;
                        step_d  = '0;
                        tms_d   = tms_bit(w_post, 2'd0);
                        tdi_d   = 1'b0;
                    end else begin
                        bit_d = w_bit_nxt;
                        tdi_d = tdi_vec_q[w_bit_nxt];
                        tms_d = (w_bit_nxt == last_q);
                    end
                end
            end
            ST_EXIT: begin
                if (w_fall) begin
                    if (step_q == STEP_W'(w_post_last)) begin
                        state_d = ST_RESP;
                    end else begin
                        step_d = w_step_nxt;
                        tms_d  = tms_bit(w_post, w_step_nxt[1:0]);
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            bit_q      <= '0;
            last_q     <= '0;
            is_reset_q <= 1'b0;
            is_ir_q    <= 1'b0;
            pause_q    <= 1'b0;
            tdi_vec_q  <= '0;
            tdo_vec_q  <= '0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            synced_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            is_reset_q <= is_reset_d;
            is_ir_q    <= is_ir_d;
            pause_q    <= pause_d;
            tdi_vec_q  <= tdi_vec_d;
            tdo_vec_q  <= tdo_vec_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            synced_q   <= synced_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_tdo   = tdo_vec_q;
    assign busy_o        = w_busy;
    assign tms_o         = tms_q;
    assign tdi_o         = tdi_q;
    assign tap_synced_o  = synced_q;

endmodule
`default_nettype wire
